// File: rtl/pipe_pkg.sv
// Shared definitions for the memory / writeback stage.
//   state_t        : memory-stage FSM encoding
//   mwb_t          : one M/WB pipeline register entry
//   TIMEOUT_DEFAULT: default cycles an access may stay outstanding
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef struct packed {
    logic        valid;
    logic        memRead;
    logic        regWrite;
    logic        writeR7;
    logic        halt;
    logic        err;
    logic [2:0]  writeRegSel;
    logic [15:0] alu_result;
    logic [15:0] read_data;
    logic [15:0] pc_plus_2;
  } mwb_t;

endpackage

// File: rtl/mwb_reg.sv
// M/WB pipeline register.
//   clk, rst   : clock, synchronous active-high reset (clears everything)
//   bubble     : clear control fields, hold data fields
//   err_inj    : load valid=1/err=1 with all other controls 0, hold data
//   rdata_load : read_data takes nxt.read_data on a normal load
//   nxt        : entry to load on a normal (non-bubble, non-error) cycle
//   cur        : registered entry seen by writeback and forwarding
module mwb_reg
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bubble,
  input  logic err_inj,
  input  logic rdata_load,
  input  mwb_t nxt,
  output mwb_t cur
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
    end else if (bubble || err_inj) begin
      cur.valid    <= err_inj;
      cur.err      <= err_inj;
      cur.memRead  <= 1'b0;
      cur.regWrite <= 1'b0;
      cur.writeR7  <= 1'b0;
      cur.halt     <= 1'b0;
    end else begin
      cur.valid       <= nxt.valid;
      cur.memRead     <= nxt.memRead;
      cur.regWrite    <= nxt.regWrite;
      cur.writeR7     <= nxt.writeR7;
      cur.halt        <= nxt.halt;
      cur.err         <= nxt.err;
      cur.writeRegSel <= nxt.writeRegSel;
      cur.alu_result  <= nxt.alu_result;
      cur.pc_plus_2   <= nxt.pc_plus_2;
      if (rdata_load) cur.read_data <= nxt.read_data;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-stage controller plus M/WB register.
//   X/M inputs (*_XM)       : instruction currently in the memory stage
//   mem_en/wr/addr/wdata    : request to the data memory, held until mem_done
//   mem_rdata, mem_done     : response; a hit may complete in the issue cycle
//   stall_mem               : freezes PC, F/D, D/X and X/M while outstanding
//   *_MWB                   : registered results for writeback / forwarding
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_XM,
  input  logic        memRead_XM,
  input  logic        memWrite_XM,
  input  logic [15:0] alu_result_XM,
  input  logic [15:0] write_data_XM,
  input  logic [2:0]  writeRegSel_XM,
  input  logic        regWrite_XM,
  input  logic        writeR7_XM,
  input  logic [15:0] pc_plus_2_XM,
  input  logic        halt_XM,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall_mem,
  output logic        valid_MWB,
  output logic        memRead_MWB,
  output logic        regWrite_MWB,
  output logic        writeR7_MWB,
  output logic        halt_MWB,
  output logic        err_MWB,
  output logic [2:0]  writeRegSel_MWB,
  output logic [15:0] alu_result_MWB,
  output logic [15:0] read_data_MWB,
  output logic [15:0] pc_plus_2_MWB
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             is_mem, misalign, acc, mis_err;
  mwb_t             nxt, cur;

  // Read and write together is illegal and handled like a misaligned access.
  assign is_mem   = valid_XM & (memRead_XM | memWrite_XM) & ~halt_XM;
  assign misalign = alu_result_XM[0] | (memRead_XM & memWrite_XM);
  assign acc      = is_mem & ~misalign;
  assign mis_err  = is_mem & misalign;

  // X/M is frozen while in WAIT, so driving straight from it holds the request.
  assign mem_en    = ~rst & (((state == IDLE) & acc) | (state == WAIT));
  assign mem_wr    = mem_en & memWrite_XM;
  assign mem_addr  = mem_en ? alu_result_XM : '0;
  assign mem_wdata = mem_en ? write_data_XM : '0;
  assign stall_mem = mem_en & ~mem_done;

  assign cnt_next = wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && !mem_done) begin
            state    <= WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (mem_done) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (cnt_next >= CNT_W'(TIMEOUT)) begin
            state    <= ERR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= cnt_next;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    nxt             = '0;
    nxt.valid       = valid_XM;
    nxt.memRead     = valid_XM & memRead_XM;
    nxt.regWrite    = valid_XM & regWrite_XM & ~mis_err;
    nxt.writeR7     = valid_XM & writeR7_XM;
    nxt.halt        = valid_XM & halt_XM;
    nxt.err         = mis_err;
    nxt.writeRegSel = writeRegSel_XM;
    nxt.alu_result  = alu_result_XM;
    nxt.read_data   = mem_rdata;
    nxt.pc_plus_2   = pc_plus_2_XM;
  end

  mwb_reg u_mwb_reg (
    .clk        (clk),
    .rst        (rst),
    .bubble     (stall_mem),
    .err_inj    (state == ERR),
    .rdata_load (mem_en & ~memWrite_XM & mem_done),
    .nxt        (nxt),
    .cur        (cur)
  );

  assign valid_MWB       = cur.valid;
  assign memRead_MWB     = cur.memRead;
  assign regWrite_MWB    = cur.regWrite;
  assign writeR7_MWB     = cur.writeR7;
  assign halt_MWB        = cur.halt;
  assign err_MWB         = cur.err;
  assign writeRegSel_MWB = cur.writeRegSel;
  assign alu_result_MWB  = cur.alu_result;
  assign read_data_MWB   = cur.read_data;
  assign pc_plus_2_MWB   = cur.pc_plus_2;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-stage controller plus M/WB pipeline register for the 5-stage core.
- Takes X/M-stage signals and drives a variable-latency data memory/cache through a request/done handshake.
- Stalls the front of the pipe while an access is outstanding.
- Registers the *_MWB values that writeback and the forwarding unit consume.
- Inserts a bubble into M/WB on every stall cycle, so forwarding never sees stale or duplicated MWB state.

Parameters:
- TIMEOUT, 64, max cycles an access may stay outstanding before err_MWB is raised.
- CNT_W, 7, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- valid_XM  in  1  X/M holds a real instruction
- memRead_XM  in  1  load
- memWrite_XM  in  1  store
- alu_result_XM  in  16  ALU result / effective address
- write_data_XM  in  16  store data
- writeRegSel_XM  in  3  destination register
- regWrite_XM  in  1  instruction writes the register file
- writeR7_XM  in  1  JAL/JALR link write
- pc_plus_2_XM  in  16  link value
- halt_XM  in  1  HALT in X/M
- mem_en  out  1  memory request
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  request address
- mem_wdata  out  16  store data
- mem_rdata  in  16  read data, valid when mem_done
- mem_done  in  1  access complete this cycle (a hit may complete in the issue cycle)
- stall_mem  out  1  freeze PC, F/D, D/X and X/M
- valid_MWB, memRead_MWB, regWrite_MWB, writeR7_MWB, halt_MWB, err_MWB  out  1 each  registered M/WB control
- writeRegSel_MWB  out  3  registered destination
- alu_result_MWB, read_data_MWB, pc_plus_2_MWB  out  16 each  registered data

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0. Reset mid-access drops the request immediately (mem_en=0 the next cycle). The memory side must also be reset.
- Access condition: acc = valid_XM & (memRead_XM | memWrite_XM) & ~halt_XM & ~misalign, where misalign = alu_result_XM[0].
- memRead_XM and memWrite_XM both high is illegal. Treat it as misalign.
- IDLE state:
  - If acc: mem_en=1, mem_wr=memWrite_XM, mem_addr=alu_result_XM, mem_wdata=write_data_XM (all combinational).
  - If mem_done in the same cycle: latch the result into M/WB; stay IDLE; stall_mem=0.
  - Otherwise: go to WAIT; stall_mem=1; counter=1.
- WAIT state:
  - mem_en, mem_wr, mem_addr and mem_wdata are held. The inputs are stable because X/M is frozen by stall_mem.
  - stall_mem = ~mem_done.
  - On mem_done: latch into M/WB, go to IDLE, clear the counter.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: go to ERR.
- ERR state:
  - mem_en=0, stall_mem=0.
  - Load the M/WB register with valid=1, err=1, regWrite=0.
  - Return to IDLE next cycle.
- Stall cycle (stall_mem=1): M/WB loads a bubble (valid, regWrite, memRead, writeR7, halt, err all 0). Data fields keep their previous values.
- Normal latch (non-stall, non-ERR): all *_MWB fields load from *_XM. read_data_MWB loads mem_rdata when memRead_XM & mem_done; otherwise it holds.
  - Stores: regWrite_MWB follows regWrite_XM (0 for stores).
  - Misaligned access: no request; err_MWB=1; regWrite_MWB=0.
  - Non-memory instruction: passes through with 1-cycle latency.
  - valid_XM=0: bubble.
- halt_XM: never issues a request; propagates as halt_MWB.
- mem_done while not requesting is ignored.
- Latency: hit = 1 cycle (same as ALU ops); miss = N+1 cycles, where N = cycles until mem_done.

Decomposition:
- Shared package (pipe_pkg): state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2) and TIMEOUT default.
- One natural sub-module: mwb_reg, the M/WB register with load/bubble/err-inject controls.
- The FSM, request drive and counter stay in mem_wb_stage.

Test Plan:
- ALU op: valid=1, regWrite=1, alu_result=16'h1234, dest=3 -> next cycle valid_MWB=1, alu_result_MWB=16'h1234, writeRegSel_MWB=3; mem_en never 1.
- Load hit: memRead=1, addr=16'h0040, mem_done same cycle with rdata=16'hBEEF -> stall_mem=0; next cycle read_data_MWB=16'hBEEF, memRead_MWB=1.
- Load miss: mem_done arrives 4 cycles after issue -> stall_mem=1 for 4 cycles; M/WB holds a bubble (regWrite_MWB=0) during the stall; mem_addr stable at 16'h0040; data lands the cycle after mem_done.
- Store: memWrite=1, addr=16'h0010, wdata=16'h00AA, done after 2 cycles -> mem_wr=1 for both cycles; regWrite_MWB=0.
- Misaligned and timeout: addr=16'h0011 -> mem_en=0, err_MWB=1 next cycle. mem_done held 0 with TIMEOUT=8 -> err_MWB=1 after 8 stall cycles, then stall_mem=0.
- Reset mid-WAIT: rst=1 during cycle 2 of a miss -> next cycle all outputs 0, mem_en=0, state IDLE.
